// File: rtl/bcd_disp_pkg.sv
// Shared types, constants and helpers for the multiplexed BCD display scanner.
package bcd_disp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [3:0]  BCD_MAX    = 4'd9;
    localparam logic [3:0]  BCD_BLANK  = 4'h0;
    localparam int unsigned MAX_DIGITS = 16;
    localparam int unsigned MAX_BITS   = 4 * MAX_DIGITS;

    // Bit i set when digits i..n-1 are all zero; digit 0 is never blanked.
    function automatic logic [MAX_DIGITS-1:0] blank_mask(
        input logic [MAX_BITS-1:0] value,
        input int unsigned         n
    );
        logic                  seen;
        logic [MAX_DIGITS-1:0] mask;
        seen = 1'b0;
        mask = '0;
        for (int i = int'(MAX_DIGITS) - 1; i >= 0; i--) begin
            if (i < int'(n)) begin
                if (value[4*i +: 4] != 4'h0) seen = 1'b1;
                mask[i] = !seen && (i != 0);
            end
        end
        return mask;
    endfunction

    // High when any of the low n digits is not a valid BCD digit.
    function automatic logic has_bad_digit(
        input logic [MAX_BITS-1:0] value,
        input int unsigned         n
    );
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < int'(MAX_DIGITS); i++) begin
            if ((i < int'(n)) && (value[4*i +: 4] > BCD_MAX)) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_display_scanner_tick_gen.sv
// Slot prescaler: tick is high during the cycle the count sits at PRESCALE-1.
module tick_gen #(
    parameter int unsigned PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    // Next count: cleared on request, wraps after PRESCALE-1.
    always_comb begin
        count_nxt = count + CW'(1);
        if (clear || (count == CW'(PRESCALE - 1))) count_nxt = '0;
    end

    // Count register; tick is registered from the next count so it lines up with the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            count <= count_nxt;
            tick  <= (count_nxt == CW'(PRESCALE - 1));
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed, double-buffered scanner feeding one BCD-to-7-segment decoder.
// The slot counters run one cycle ahead of the registered display outputs, so
// frame_done marks the last displayed cycle of a frame and is the load boundary.
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 1000,
    parameter int unsigned BLANK_LZ   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    output logic [3:0]              bcd,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    blank,
    output logic                    frame_done,
    output logic                    load_pending,
    output logic                    err
);

    localparam int unsigned IW = $clog2(NUM_DIGITS);

    state_t                  state;
    state_t                  state_nxt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] active_nxt;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] shadow_nxt;
    logic                    pending_nxt;
    logic                    tick;
    logic                    clear;
    logic                    boundary;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   sel;
    logic [3:0]              digit;
    logic                    blanked;
    logic                    lit;
    logic [3:0]              bcd_nxt;
    logic [NUM_DIGITS-1:0]   digit_en_nxt;
    logic                    blank_nxt;
    logic                    frame_done_nxt;
    logic                    err_nxt;

    assign clear    = (state == IDLE) || !enable;
    assign boundary = (state == SCAN) && enable && frame_done;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (tick)
    );

    // Digit index advances on each prescaler tick and wraps at the last digit.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx <= '0;
        end else if (tick) begin
            idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, value buffering and next display outputs.
    always_comb begin
        state_nxt   = state;
        active_nxt  = active;
        shadow_nxt  = shadow;
        pending_nxt = load_pending;

        case (state)
            IDLE: begin
                if (enable) state_nxt = SCAN;
                if (load)   active_nxt = value_in;
            end
            SCAN: begin
                if (!enable) state_nxt = IDLE;
                if (!enable || boundary) begin
                    // Frame edge or scan exit: newest value wins, shadow retires.
                    if (load)              active_nxt = value_in;
                    else if (load_pending) active_nxt = shadow;
                    pending_nxt = 1'b0;
                end else if (load) begin
                    shadow_nxt  = value_in;
                    pending_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        lz_mask = NUM_DIGITS'(blank_mask(MAX_BITS'(active_nxt), NUM_DIGITS));
        digit   = BCD_BLANK;
        blanked = 1'b0;
        sel     = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx == IW'(i)) begin
                digit   = active_nxt[4*i +: 4];
                blanked = (BLANK_LZ != 0) && lz_mask[i];
                sel[i]  = 1'b1;
            end
        end

        lit          = (state == SCAN) && enable;
        bcd_nxt      = BCD_BLANK;
        digit_en_nxt = '0;
        blank_nxt    = 1'b1;
        if (lit && !blanked) begin
            bcd_nxt      = digit;
            digit_en_nxt = sel;
            blank_nxt    = 1'b0;
        end

        frame_done_nxt = lit && tick && (idx == IW'(NUM_DIGITS - 1));
        err_nxt        = has_bad_digit(MAX_BITS'(active_nxt), NUM_DIGITS);
    end

    // Value buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            active       <= '0;
            shadow       <= '0;
            load_pending <= 1'b0;
            err          <= 1'b0;
            bcd          <= BCD_BLANK;
            digit_en     <= '0;
            blank        <= 1'b1;
            frame_done   <= 1'b0;
        end else begin
            active       <= active_nxt;
            shadow       <= shadow_nxt;
            load_pending <= pending_nxt;
            err          <= err_nxt;
            bcd          <= bcd_nxt;
            digit_en     <= digit_en_nxt;
            blank        <= blank_nxt;
            frame_done   <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench: directed scenarios plus random traffic against a
// display-level model (frame position counter, value buffers).
module tb_bcd_display_scanner;

    localparam int ND    = 4;
    localparam int PS    = 4;
    localparam int FRAME = ND * PS;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  bcd;
    logic [3:0]  digit_en;
    logic        blank;
    logic        frame_done;
    logic        load_pending;
    logic        err;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Model: m_p is the displayed frame position (-1 = scanning but not yet lit).
    bit          m_scan;
    int          m_p;
    logic [15:0] m_act;
    logic [15:0] m_sh;
    bit          m_pend;

    bcd_display_scanner #(
        .NUM_DIGITS(ND),
        .PRESCALE  (PS),
        .BLANK_LZ  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .load        (load),
        .value_in    (value_in),
        .bcd         (bcd),
        .digit_en    (digit_en),
        .blank       (blank),
        .frame_done  (frame_done),
        .load_pending(load_pending),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [15:0] e_bcd;
        logic [15:0] e_en;
        logic        e_blank;
        logic        e_fd;
        logic        e_err;
        int          slot;
        e_bcd   = 16'h0;
        e_en    = 16'h0;
        e_blank = 1'b1;
        e_fd    = 1'b0;
        if (m_scan && m_p >= 0) begin
            slot = m_p / PS;
            if (slot == 0 || (m_act >> (4 * slot)) != 16'h0) begin
                e_en    = 16'(1) << slot;
                e_bcd   = (m_act >> (4 * slot)) & 16'hF;
                e_blank = 1'b0;
            end
            e_fd = (m_p == FRAME - 1);
        end
        e_err = 1'b0;
        for (int i = 0; i < ND; i++)
            if (((m_act >> (4 * i)) & 16'hF) > 16'd9) e_err = 1'b1;
        chk("bcd",          16'(bcd),          e_bcd);
        chk("digit_en",     16'(digit_en),     e_en);
        chk("blank",        16'(blank),        16'(e_blank));
        chk("frame_done",   16'(frame_done),   16'(e_fd));
        chk("load_pending", 16'(load_pending), 16'(m_pend));
        chk("err",          16'(err),          16'(e_err));
    endtask

    task automatic step(input bit en, input bit ld, input logic [15:0] val);
        enable   = en;
        load     = ld;
        value_in = val;
        @(posedge clk);
        if (!m_scan) begin
            if (ld) m_act = val;
            if (en) begin
                m_scan = 1'b1;
                m_p    = -1;
            end
        end else if (!en || m_p == FRAME - 1) begin
            if (ld)          m_act = val;
            else if (m_pend) m_act = m_sh;
            m_pend = 1'b0;
            m_p    = 0;
            if (!en) m_scan = 1'b0;
        end else begin
            if (ld) begin
                m_sh   = val;
                m_pend = 1'b1;
            end
            m_p++;
        end
        #1;
        check_all();
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        int          mode;
        int          nz;
        mode = int'($urandom_range(0, 3));
        nz   = int'($urandom_range(0, ND));
        v    = 16'h0;
        for (int i = 0; i < ND; i++) begin
            if (mode == 3)                v[4*i +: 4] = 4'($urandom_range(0, 15));
            else if (mode == 0 || i < nz) v[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    task automatic do_reset(input int n);
        rst      = 1'b1;
        enable   = 1'($urandom_range(0, 1));
        load     = 1'b1;
        value_in = rand_val();
        repeat (n) begin
            @(posedge clk);
            m_scan = 1'b0;
            m_p    = 0;
            m_act  = 16'h0;
            m_sh   = 16'h0;
            m_pend = 1'b0;
            #1;
            check_all();
        end
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b1, 1'b0, 16'h0);
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; load = 1'b0; value_in = 16'h0;

        // Reset (with a competing load) then idle.
        do_reset(2);
        repeat (20) step(1'b0, 1'b0, 16'h0);

        // Full scan of 1234.
        step(1'b0, 1'b1, 16'h1234);
        run(3 * FRAME);

        // Tear-free update mid-frame.
        run(5);
        step(1'b1, 1'b1, 16'h9999);
        run(2 * FRAME);

        // Leading-zero blanking.
        step(1'b1, 1'b1, 16'h0050);
        run(2 * FRAME);
        step(1'b1, 1'b1, 16'h0000);
        run(2 * FRAME);

        // Boundary collision: shadow holds 1111, 2222 arrives with frame_done.
        run(3);
        step(1'b1, 1'b1, 16'h1111);
        for (int k = 0; k < 2 * FRAME && m_p != FRAME - 1; k++) step(1'b1, 1'b0, 16'h0);
        chk("collision_fd", 16'(frame_done), 16'h1);
        step(1'b1, 1'b1, 16'h2222);
        chk("collision_pend", 16'(load_pending), 16'h0);
        run(FRAME + 2);

        // Invalid digit, then disable mid-slot and restart.
        step(1'b1, 1'b1, 16'h00A1);
        run(2 * FRAME + 5);
        step(1'b0, 1'b0, 16'h0);
        chk("disable_digit_en", 16'(digit_en), 16'h0);
        repeat (3) step(1'b0, 1'b0, 16'h0);
        run(FRAME + 3);

        // Pending shadow transferred when scanning stops.
        step(1'b1, 1'b1, 16'h4321);
        step(1'b0, 1'b0, 16'h0);
        run(FRAME + 2);

        // Random traffic.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(1);
            end else begin
                step(1'($urandom_range(0, 15) != 0),
                     1'($urandom_range(0, 7) == 0),
                     rand_val());
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Time-multiplexed scanner that drives a multi-digit common-bus 7-segment display through a single BCD-to-7-segment decoder. It holds a packed multi-digit BCD value and presents one digit per refresh slot on `bcd`, which connects directly to the `bcd` input of `BCDto7Segment`, together with a one-hot digit enable. New values are double-buffered and applied only at frame boundaries, so a displayed frame is never torn.

## Interface
- `NUM_DIGITS`, 4: number of display digits; must be ≥2.
- `PRESCALE`, 1000: clock cycles per digit slot; must be ≥2.
- `BLANK_LZ`, 1: 1 enables leading-zero blanking.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  scan enable.
- `load`  in  1  one-cycle strobe; capture `value_in`.
- `value_in`  in  4*NUM_DIGITS  packed BCD; digit 0 (least significant) in bits [3:0].
- `bcd`  out  4  current digit to the decoder.
- `digit_en`  out  NUM_DIGITS  one-hot active-high digit select; all-zero when no digit is lit.
- `blank`  out  1  current slot blanked; downstream gates segments.
- `frame_done`  out  1  one-cycle pulse on the last cycle of the final slot.
- `load_pending`  out  1  shadow value waiting for a frame boundary.
- `err`  out  1  active value contains a digit >9.

## Operation
- Two states. In IDLE, `enable`=0. In SCAN, `enable`=1.
- IDLE:
  - Prescaler and digit index are held at 0.
  - `digit_en`=0, `blank`=1, `bcd`=0.
- IDLE→SCAN when `enable` is sampled high. SCAN→IDLE when it is sampled low. The counters clear on entry to IDLE.
- Prescaler runs 0..PRESCALE-1. On PRESCALE-1 the digit index advances and wraps from NUM_DIGITS-1 to 0.
- A frame boundary is the cycle where prescaler=PRESCALE-1 and index=NUM_DIGITS-1. `frame_done` asserts on that cycle.
- Load handling:
  - `load` in IDLE: `value_in` is written straight to the active register.
  - `load` in SCAN, not on a boundary: written to the shadow register; `load_pending`←1. A later load overwrites the shadow.
  - At a boundary with `load_pending`=1 and no `load`: shadow→active, `load_pending`←0.
  - At a boundary with `load` asserted: `value_in`→active directly, `load_pending`←0. Any older shadow is discarded.
  - Leaving SCAN with `load_pending`=1: the shadow is transferred to active on the same edge.
- Blanking:
  - With BLANK_LZ=1, digit i is blanked if digits i..NUM_DIGITS-1 of the active value are all 0. Digit 0 is never blanked.
  - A blanked slot drives `digit_en`=0, `blank`=1 and `bcd`=0.
- Digits >9 are passed through unchanged and count as nonzero for blanking.
- `err` is recomputed from the active value whenever the active register is written.

## Timing
- All outputs are registered.
- Reset values:
  - Outputs: `bcd`=0, `digit_en`=0, `blank`=1, `frame_done`=0, `load_pending`=0, `err`=0.
  - Internal: active=0, shadow=0, state IDLE, prescaler=0, index=0.
- `rst` overrides everything, including a simultaneous `load`. Reset mid-frame abandons the frame without a `frame_done` pulse.
- `enable` sampled high at edge N: digit 0 is driven from edge N+1 for exactly PRESCALE cycles.
- Each slot lasts PRESCALE cycles. A frame lasts NUM_DIGITS*PRESCALE cycles.
- Load latency:
  - In IDLE, the value is in active one cycle after `load`.
  - In SCAN, it is displayed from the first slot after the next boundary.
- `err` updates in the same cycle as the active register.

## Structure
- Package `bcd_disp_pkg` holds:
  - the state enum (IDLE, SCAN);
  - `BCD_MAX`=9 and `BCD_BLANK`=4'h0;
  - a function returning the per-digit blank mask.
- Sub-module `tick_gen` is the parameterised prescaler. Ports: clk, rst, clear, tick. `tick` pulses on count PRESCALE-1.

## Test plan
Bench uses NUM_DIGITS=4, PRESCALE=4.
- Reset then idle:
  - Stimulus: `rst` for 2 cycles, `enable`=0 for 20 cycles.
  - Required: `digit_en`=0, `blank`=1, `bcd`=0, `frame_done`=0 throughout.
- Full scan:
  - Stimulus: load 16'h1234 in IDLE, then assert `enable`.
  - Required: `digit_en`/`bcd` sequence is 0001/4, 0010/3, 0100/2, 1000/1, each for 4 cycles. `frame_done` pulses every 16 cycles.
- Leading-zero blanking:
  - With value 16'h0050, digits 3 and 2 show `blank`=1, `digit_en`=0.
  - With value 16'h0000, only digit 0 is lit, showing 0.
- Tear-free update:
  - Stimulus: load 16'h9999 mid-frame while 16'h1234 is showing.
  - Required: `load_pending`=1 until the boundary. The current frame completes as 1234, then the next frame shows 9999.
- Boundary collision:
  - Stimulus: shadow holds 16'h1111, then load 16'h2222 on the `frame_done` cycle.
  - Required: the next frame shows 2222 and `load_pending`=0.
- Error and disable:
  - Stimulus: load 16'h00A1.
  - Required: `err`=1 and `bcd`=A is shown in the digit-1 slot.
  - Stimulus: drop `enable` mid-slot.
  - Required: next cycle `digit_en`=0. Re-enabling restarts at digit 0.
